// File: rtl/branch_amend_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_amend_stage_pkg
// Description : Shared constants for the multi-lane branch amend stage:
//               default widths and the repair-action bit encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_amend_stage_pkg;

    // Default widths of the stage.
    localparam int DEF_LANES  = 2;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_GPR_W  = 5;
    localparam int DEF_CKPT_W = 8;
    localparam int DEF_ACT_W  = 4;
    localparam int DEF_CNT_W  = 16;

    // Repair-action bit positions. Only NEED_REPAIR is consumed here; the
    // other bits travel with the flush to tell the front end what to restore.
    localparam int NEED_REPAIR      = 0;
    localparam int ACT_BIT_RAS      = 1;
    localparam int ACT_BIT_GHR      = 2;
    localparam int ACT_BIT_INDIRECT = 3;

endpackage : branch_amend_stage_pkg
`default_nettype wire

// File: rtl/branch_amend_stage_lowest_set_pe.sv
`default_nettype none
// ============================================================================
// Module      : lowest_set_pe
// Description : Priority encoder returning the index of the lowest set bit,
//               a found flag, and a mask of every bit position above it.
// Revision    : 1.0 - initial release
// ============================================================================
module lowest_set_pe #(
    parameter  int N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found,
    output logic [N-1:0]     o_above
);

    // Scan from bit 0 upward; once the first set bit is seen, every higher
    // position is marked in the above-mask.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        o_above = '0;
        for (int i = 0; i < N; i++) begin
            if (o_found) begin
                o_above[i] = 1'b1;
            end else if (i_vec[i]) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end

endmodule : lowest_set_pe
`default_nettype wire

// File: rtl/branch_amend_stage.sv
`default_nettype none
// ============================================================================
// Module      : branch_amend_stage
// Description : Multi-lane branch repair stage between EXE_up and PREMEM.
//               Picks the oldest mispredicted lane, raises one front-end
//               flush per held group, squashes younger lanes and stalls on
//               a MEM-stage hazard. Exports a saturating mispredict count.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_amend_stage
    import branch_amend_stage_pkg::*;
#(
    parameter  int LANES  = DEF_LANES,
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int GPR_W  = DEF_GPR_W,
    parameter  int CKPT_W = DEF_CKPT_W,
    parameter  int ACT_W  = DEF_ACT_W,
    parameter  int CNT_W  = DEF_CNT_W,
    localparam int LANE_W = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_has_risk_i,
    input  logic                    exc_flush_i,
    input  logic                    down_allowin_i,
    input  logic [LANES-1:0]        up_valid_i,
    input  logic [LANES*GPR_W-1:0]  up_write_num_i,
    input  logic [LANES*DATA_W-1:0] up_vaddr_i,
    input  logic [LANES*DATA_W-1:0] up_alu_res_i,
    input  logic [LANES*DATA_W-1:0] up_corr_dest_i,
    input  logic [LANES-1:0]        up_corr_take_i,
    input  logic [LANES*ACT_W-1:0]  up_repair_act_i,
    input  logic [LANES*CKPT_W-1:0] up_ckpt_i,
    output logic                    ok_to_change_o,
    output logic [LANES-1:0]        valid_o,
    output logic [LANES-1:0]        fwd_valid_o,
    output logic [LANES*GPR_W-1:0]  write_num_o,
    output logic [LANES*DATA_W-1:0] vaddr_o,
    output logic [LANES*DATA_W-1:0] alu_res_o,
    output logic                    flush_o,
    output logic [LANE_W-1:0]       flush_lane_o,
    output logic [DATA_W-1:0]       flush_vaddr_o,
    output logic [DATA_W-1:0]       flush_dest_o,
    output logic                    flush_take_o,
    output logic [CKPT_W-1:0]       flush_ckpt_o,
    output logic [ACT_W-1:0]        flush_act_o,
    output logic [CNT_W-1:0]        mispredict_cnt_o
);

    // Held group state.
    logic [LANES-1:0]        r_hv;
    logic [LANES*GPR_W-1:0]  r_write_num;
    logic [LANES*DATA_W-1:0] r_vaddr;
    logic [LANES*DATA_W-1:0] r_alu_res;
    logic [LANES*DATA_W-1:0] r_corr_dest;
    logic [LANES-1:0]        r_corr_take;
    logic [LANES*ACT_W-1:0]  r_act;
    logic [LANES*CKPT_W-1:0] r_ckpt;
    logic                    r_flushed;
    logic [CNT_W-1:0]        r_cnt;

    logic [LANES-1:0]        w_need;
    logic [LANES-1:0]        w_kill;
    logic [LANE_W-1:0]       w_k;
    logic                    w_found;
    logic                    w_hold;
    logic                    w_load;
    logic                    w_flush;

    // Per-lane repair request: a held lane whose action flags a mispredict.
    always_comb begin
        w_need = '0;
        for (int i = 0; i < LANES; i++) begin
            w_need[i] = r_hv[i] & r_act[i*ACT_W + NEED_REPAIR];
        end
    end

    // Oldest repairing lane, plus the mask of younger lanes to squash.
    lowest_set_pe #(
        .N (LANES)
    ) u_flush_pe (
        .i_vec   (w_need),
        .o_idx   (w_k),
        .o_found (w_found),
        .o_above (w_kill)
    );

    // A pending repair cannot proceed while MEM may still raise an exception.
    assign w_hold  = mem_has_risk_i & w_found;
    assign w_load  = down_allowin_i & ~w_hold;
    assign w_flush = w_found & ~mem_has_risk_i & ~r_flushed;

    assign ok_to_change_o = ~w_hold;
    assign valid_o        = r_hv & ~w_kill
                          & {LANES{~w_hold & down_allowin_i & ~exc_flush_i}};
    assign fwd_valid_o    = r_hv & ~w_kill & {LANES{~w_hold}};

    assign write_num_o = r_write_num;
    assign vaddr_o     = r_vaddr;
    assign alu_res_o   = r_alu_res;

    assign flush_o       = w_flush;
    assign flush_lane_o  = w_k;
    assign flush_vaddr_o = r_vaddr[int'(w_k)*DATA_W +: DATA_W];
    assign flush_dest_o  = r_corr_dest[int'(w_k)*DATA_W +: DATA_W];
    assign flush_take_o  = r_corr_take[w_k];
    assign flush_ckpt_o  = r_ckpt[int'(w_k)*CKPT_W +: CKPT_W];
    assign flush_act_o   = r_act[int'(w_k)*ACT_W +: ACT_W];

    assign mispredict_cnt_o = r_cnt;

    // Group register: clear on reset/exception, capture on load (dropping
    // wrong-path input behind a flush), and remember that a flush was sent.
    always_ff @(posedge clk) begin
        if (rst || exc_flush_i) begin
            r_hv        <= '0;
            r_write_num <= '0;
            r_vaddr     <= '0;
            r_alu_res   <= '0;
            r_corr_dest <= '0;
            r_corr_take <= '0;
            r_act       <= '0;
            r_ckpt      <= '0;
            r_flushed   <= 1'b0;
        end else if (w_load) begin
            r_hv        <= up_valid_i & {LANES{~w_flush}};
            r_write_num <= up_write_num_i;
            r_vaddr     <= up_vaddr_i;
            r_alu_res   <= up_alu_res_i;
            r_corr_dest <= up_corr_dest_i;
            r_corr_take <= up_corr_take_i;
            r_act       <= up_repair_act_i;
            r_ckpt      <= up_ckpt_i;
            r_flushed   <= 1'b0;
        end else if (w_flush) begin
            r_flushed   <= 1'b1;
        end
    end

    // Saturating flush counter; survives exception flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_flush && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule : branch_amend_stage
`default_nettype wire

// File: tb/tb_branch_amend_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_amend_stage
// Description : Directed scoreboard bench for branch_amend_stage (2 lanes,
//               2-bit counter so saturation is reachable).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_amend_stage;

    localparam int LANES  = 2;
    localparam int DATA_W = 32;
    localparam int GPR_W  = 5;
    localparam int CKPT_W = 8;
    localparam int ACT_W  = 4;
    localparam int CNT_W  = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    mem_has_risk_i;
    logic                    exc_flush_i;
    logic                    down_allowin_i;
    logic [LANES-1:0]        up_valid_i;
    logic [LANES*GPR_W-1:0]  up_write_num_i;
    logic [LANES*DATA_W-1:0] up_vaddr_i;
    logic [LANES*DATA_W-1:0] up_alu_res_i;
    logic [LANES*DATA_W-1:0] up_corr_dest_i;
    logic [LANES-1:0]        up_corr_take_i;
    logic [LANES*ACT_W-1:0]  up_repair_act_i;
    logic [LANES*CKPT_W-1:0] up_ckpt_i;
    logic                    ok_to_change_o;
    logic [LANES-1:0]        valid_o;
    logic [LANES-1:0]        fwd_valid_o;
    logic [LANES*GPR_W-1:0]  write_num_o;
    logic [LANES*DATA_W-1:0] vaddr_o;
    logic [LANES*DATA_W-1:0] alu_res_o;
    logic                    flush_o;
    logic                    flush_lane_o;
    logic [DATA_W-1:0]       flush_vaddr_o;
    logic [DATA_W-1:0]       flush_dest_o;
    logic                    flush_take_o;
    logic [CKPT_W-1:0]       flush_ckpt_o;
    logic [ACT_W-1:0]        flush_act_o;
    logic [CNT_W-1:0]        mispredict_cnt_o;

    branch_amend_stage #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .GPR_W  (GPR_W),
        .CKPT_W (CKPT_W),
        .ACT_W  (ACT_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_has_risk_i   (mem_has_risk_i),
        .exc_flush_i      (exc_flush_i),
        .down_allowin_i   (down_allowin_i),
        .up_valid_i       (up_valid_i),
        .up_write_num_i   (up_write_num_i),
        .up_vaddr_i       (up_vaddr_i),
        .up_alu_res_i     (up_alu_res_i),
        .up_corr_dest_i   (up_corr_dest_i),
        .up_corr_take_i   (up_corr_take_i),
        .up_repair_act_i  (up_repair_act_i),
        .up_ckpt_i        (up_ckpt_i),
        .ok_to_change_o   (ok_to_change_o),
        .valid_o          (valid_o),
        .fwd_valid_o      (fwd_valid_o),
        .write_num_o      (write_num_o),
        .vaddr_o          (vaddr_o),
        .alu_res_o        (alu_res_o),
        .flush_o          (flush_o),
        .flush_lane_o     (flush_lane_o),
        .flush_vaddr_o    (flush_vaddr_o),
        .flush_dest_o     (flush_dest_o),
        .flush_take_o     (flush_take_o),
        .flush_ckpt_o     (flush_ckpt_o),
        .flush_act_o      (flush_act_o),
        .mispredict_cnt_o (mispredict_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  fwd;
        logic        flush;
        logic        lane;
        logic [31:0] dest;
        logic [7:0]  ckpt;
        logic [31:0] fvaddr;
        logic        take;
        logic [3:0]  act;
        logic [9:0]  wn;
        logic [63:0] alu;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic mon_ok;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, req);
        end
    endtask

    // Monitor: whenever the stage presents a handoff or a flush, compare it
    // against the oldest expected response.
    always @(negedge clk) begin
        if (!rst && (valid_o != '0 || flush_o)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_output: valid=%b flush=%b vaddr=%h, no response expected",
                         valid_o, flush_o, vaddr_o);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_ok = (valid_o === mon_e.valid) && (fwd_valid_o === mon_e.fwd) &&
                         (flush_o === mon_e.flush) && (write_num_o === mon_e.wn) &&
                         (alu_res_o === mon_e.alu);
                if (mon_e.flush)
                    mon_ok = mon_ok && (flush_lane_o === mon_e.lane) &&
                             (flush_dest_o === mon_e.dest) && (flush_ckpt_o === mon_e.ckpt) &&
                             (flush_vaddr_o === mon_e.fvaddr) && (flush_take_o === mon_e.take) &&
                             (flush_act_o === mon_e.act);
                if (!mon_ok) begin
                    n_errors++;
                    $display("FAIL response: got v=%b f=%b fl=%b ln=%0d d=%h ck=%h pc=%h tk=%b a=%h wn=%h alu=%h; expected v=%b f=%b fl=%b ln=%0d d=%h ck=%h pc=%h tk=%b a=%h wn=%h alu=%h",
                             valid_o, fwd_valid_o, flush_o, flush_lane_o, flush_dest_o, flush_ckpt_o,
                             flush_vaddr_o, flush_take_o, flush_act_o, write_num_o, alu_res_o,
                             mon_e.valid, mon_e.fwd, mon_e.flush, mon_e.lane, mon_e.dest, mon_e.ckpt,
                             mon_e.fvaddr, mon_e.take, mon_e.act, mon_e.wn, mon_e.alu);
                end
            end
        end
    end

    task automatic push(input logic [1:0] v, input logic [1:0] f, input logic fl, input logic ln,
                        input logic [31:0] dest, input logic [7:0] ckpt, input logic [31:0] fva,
                        input logic take, input logic [3:0] act, input logic [9:0] wn,
                        input logic [63:0] alu);
        exp_t e;
        e.valid = v;  e.fwd = f;   e.flush = fl;  e.lane = ln;
        e.dest = dest; e.ckpt = ckpt; e.fvaddr = fva; e.take = take;
        e.act = act;  e.wn = wn;   e.alu = alu;
        exp_q.push_back(e);
    endtask

    task automatic set_lane(input int l, input logic v, input logic [4:0] wn, input logic [31:0] pc,
                            input logic [31:0] alu, input logic [31:0] dest, input logic take,
                            input logic [3:0] act, input logic [7:0] ckpt);
        up_valid_i[l]                       = v;
        up_write_num_i[l*GPR_W +: GPR_W]    = wn;
        up_vaddr_i[l*DATA_W +: DATA_W]      = pc;
        up_alu_res_i[l*DATA_W +: DATA_W]    = alu;
        up_corr_dest_i[l*DATA_W +: DATA_W]  = dest;
        up_corr_take_i[l]                   = take;
        up_repair_act_i[l*ACT_W +: ACT_W]   = act;
        up_ckpt_i[l*CKPT_W +: CKPT_W]       = ckpt;
    endtask

    task automatic junk();
        set_lane(0, 1'b1, 5'd31, 32'hDEAD_0000, 32'hEE00, 32'hBAD0, 1'b1, 4'b0001, 8'hEE);
        set_lane(1, 1'b1, 5'd30, 32'hDEAD_0004, 32'hEE01, 32'hBAD4, 1'b1, 4'b0001, 8'hEF);
    endtask

    task automatic idle();
        up_valid_i = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_has_risk_i = 1'b0; exc_flush_i = 1'b0; down_allowin_i = 1'b1;
        up_valid_i = '0; up_write_num_i = '0; up_vaddr_i = '0; up_alu_res_i = '0;
        up_corr_dest_i = '0; up_corr_take_i = '0; up_repair_act_i = '0; up_ckpt_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_valid", valid_o, 0);
        check("rst_fwd", fwd_valid_o, 0);
        check("rst_flush", flush_o, 0);
        check("rst_ok", ok_to_change_o, 1);
        check("rst_vaddr", vaddr_o, 0);
        check("rst_alu", alu_res_o, 0);
        check("rst_wn", write_num_o, 0);
        check("rst_fdest", flush_dest_o, 0);
        check("rst_fckpt", flush_ckpt_o, 0);
        check("rst_cnt", mispredict_cnt_o, 0);
        tick();

        // A: lane 1 mispredicted, no hazard
        set_lane(0, 1'b1, 5'd3, 32'h100, 32'hA0, 32'h111,  1'b0, 4'b0010, 8'h10);
        set_lane(1, 1'b1, 5'd4, 32'h104, 32'hA1, 32'h2000, 1'b1, 4'b0011, 8'h21);
        push(2'b11, 2'b11, 1'b1, 1'b1, 32'h2000, 8'h21, 32'h104, 1'b1, 4'b0011,
             {5'd4, 5'd3}, {32'hA1, 32'hA0});
        tick();
        idle();
        tick();
        check("cnt_after_A", mispredict_cnt_o, 1);

        // B: both lanes mispredicted; lane 1 squashed. Input arriving during
        // the flush is wrong-path and must be dropped.
        set_lane(0, 1'b1, 5'd5, 32'h200, 32'hB0, 32'h3000, 1'b1, 4'b0001, 8'h30);
        set_lane(1, 1'b1, 5'd6, 32'h204, 32'hB1, 32'h4000, 1'b0, 4'b0001, 8'h40);
        push(2'b01, 2'b01, 1'b1, 1'b0, 32'h3000, 8'h30, 32'h200, 1'b1, 4'b0001,
             {5'd6, 5'd5}, {32'hB1, 32'hB0});
        tick();
        set_lane(0, 1'b1, 5'd1, 32'h900, 32'h90, 32'h0, 1'b0, 4'b0000, 8'h0);
        set_lane(1, 1'b1, 5'd2, 32'h904, 32'h91, 32'h0, 1'b0, 4'b0000, 8'h0);
        tick();
        idle();
        check("cnt_after_B", mispredict_cnt_o, 2);
        tick();
        tick();

        // C: MEM hazard for 3 cycles with lane 0 mispredicted
        mem_has_risk_i = 1'b1;
        set_lane(0, 1'b1, 5'd7, 32'h300, 32'hC0, 32'h3300, 1'b0, 4'b0101, 8'h33);
        set_lane(1, 1'b1, 5'd8, 32'h304, 32'hC1, 32'h0,    1'b0, 4'b0000, 8'h34);
        push(2'b01, 2'b01, 1'b1, 1'b0, 32'h3300, 8'h33, 32'h300, 1'b0, 4'b0101,
             {5'd8, 5'd7}, {32'hC1, 32'hC0});
        tick();
        junk();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hazard_ok", ok_to_change_o, 0);
            check("hazard_noflush", flush_o, 0);
            tick();
        end
        mem_has_risk_i = 1'b0;
        idle();
        tick();
        check("cnt_after_C", mispredict_cnt_o, 3);

        // D: downstream blocked for 4 cycles after the flush; 4th flush
        // leaves the 2-bit counter saturated.
        set_lane(0, 1'b1, 5'd9,  32'h400, 32'hD0, 32'h0,    1'b0, 4'b0000, 8'h50);
        set_lane(1, 1'b1, 5'd10, 32'h404, 32'hD1, 32'h5000, 1'b1, 4'b1001, 8'h55);
        push(2'b00, 2'b11, 1'b1, 1'b1, 32'h5000, 8'h55, 32'h404, 1'b1, 4'b1001,
             {5'd10, 5'd9}, {32'hD1, 32'hD0});
        tick();
        down_allowin_i = 1'b0;
        junk();
        repeat (3) tick();
        @(negedge clk);
        check("hold_vaddr", vaddr_o, {32'h404, 32'h400});
        check("hold_alu", alu_res_o, {32'hD1, 32'hD0});
        check("hold_noreflush", flush_o, 0);
        tick();
        down_allowin_i = 1'b1;
        idle();
        push(2'b11, 2'b11, 1'b0, 1'b0, 32'h0, 8'h0, 32'h0, 1'b0, 4'b0000,
             {5'd10, 5'd9}, {32'hD1, 32'hD0});
        tick();
        check("cnt_saturated", mispredict_cnt_o, 3);

        // F: plain group, then exception flush while full with new input
        set_lane(0, 1'b1, 5'd11, 32'h600, 32'hF0, 32'h0, 1'b0, 4'b0000, 8'h60);
        set_lane(1, 1'b1, 5'd12, 32'h604, 32'hF1, 32'h0, 1'b0, 4'b0000, 8'h61);
        push(2'b11, 2'b11, 1'b0, 1'b0, 32'h0, 8'h0, 32'h0, 1'b0, 4'b0000,
             {5'd12, 5'd11}, {32'hF1, 32'hF0});
        tick();
        set_lane(0, 1'b1, 5'd13, 32'h700, 32'h70, 32'h0, 1'b0, 4'b0000, 8'h70);
        set_lane(1, 1'b1, 5'd14, 32'h704, 32'h71, 32'h0, 1'b0, 4'b0000, 8'h71);
        tick();
        exc_flush_i = 1'b1;
        set_lane(0, 1'b1, 5'd15, 32'h800, 32'h80, 32'h0, 1'b0, 4'b0000, 8'h80);
        set_lane(1, 1'b1, 5'd16, 32'h804, 32'h81, 32'h0, 1'b0, 4'b0000, 8'h81);
        @(negedge clk);
        check("exc_valid_same_cycle", valid_o, 0);
        tick();
        exc_flush_i = 1'b0;
        idle();
        @(negedge clk);
        check("exc_valid_next", valid_o, 0);
        check("exc_fwd_next", fwd_valid_o, 0);
        check("exc_vaddr_cleared", vaddr_o, 0);
        check("exc_wn_cleared", write_num_o, 0);
        check("cnt_kept_on_exc", mispredict_cnt_o, 3);
        tick();
        tick();

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_branch_amend_stage
`default_nettype wire
